// File: rtl/frame_consensus_ctrl_pkg.sv
// Shared definitions for the frame consensus controller: FSM state encoding,
// processor color/shape codes, RESULT_OUT field positions, the timeout result
// code and small helpers used to form samples and results.
package frame_consensus_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ARM    = 2'b01,
    ST_SAMPLE = 2'b10,
    ST_DONE   = 2'b11
  } state_t;

  localparam logic [1:0] COLOR_NONE    = 2'b00;
  localparam logic [1:0] COLOR_RED     = 2'b01;
  localparam logic [1:0] COLOR_BLUE    = 2'b10;
  localparam logic [1:0] COLOR_ILLEGAL = 2'b11;

  localparam logic [2:0] SHAPE_NONE     = 3'b000;
  localparam logic [2:0] SHAPE_DIAMOND  = 3'b001;
  localparam logic [2:0] SHAPE_TRIANGLE = 3'b010;
  localparam logic [2:0] SHAPE_SQUARE   = 3'b011;
  localparam logic [2:0] SHAPE_OTHER    = 3'b100;

  localparam int RES_COLOR_LSB   = 0;
  localparam int RES_SHAPE_LSB   = 2;
  localparam int RES_RSVD_BIT    = 5;
  localparam int RES_TIMEOUT_BIT = 6;
  localparam int RES_FOUND_BIT   = 7;

  localparam logic [7:0] RESULT_TIMEOUT = 8'h40;

  // Only red and blue are trusted; anything else (or no decision) is "none".
  function automatic logic [1:0] form_color(input logic done, input logic [1:0] code);
    if (done && ((code == COLOR_RED) || (code == COLOR_BLUE))) return code;
    return COLOR_NONE;
  endfunction

  // A shape is only meaningful when a color was recognised in the same frame.
  function automatic logic [2:0] form_shape(input logic done, input logic [2:0] code,
                                            input logic [1:0] color);
    if (done && (color != COLOR_NONE)) return code;
    return SHAPE_NONE;
  endfunction

  function automatic logic [7:0] pack_result(input logic [1:0] color, input logic [2:0] shape);
    logic [7:0] r;
    r = '0;
    r[RES_COLOR_LSB +: 2]  = color;
    r[RES_SHAPE_LSB +: 3]  = shape;
    r[RES_RSVD_BIT]        = 1'b0;
    r[RES_TIMEOUT_BIT]     = 1'b0;
    r[RES_FOUND_BIT]       = (color != COLOR_NONE);
    return r;
  endfunction

endpackage

// File: rtl/frame_consensus_ctrl_if.sv
// Handshake and image-processor bus of the frame consensus controller.
//   vga_vsync_neg : vsync, low during vertical sync
//   color_done/color_in, shape_done/shape_in : processor decisions
//   req  : 4-phase request from the Arduino
//   ack  : 4-phase acknowledge, result valid
//   busy : frames being sampled
//   result_out : {found, timeout, rsvd, shape[2:0], color[1:0]}
// master = stimulus side (camera/processor/Arduino), slave = controller.
interface frame_consensus_ctrl_if;
  logic       vga_vsync_neg;
  logic       color_done;
  logic       shape_done;
  logic [1:0] color_in;
  logic [2:0] shape_in;
  logic       req;
  logic       ack;
  logic       busy;
  logic [7:0] result_out;

  modport master (
    output vga_vsync_neg, color_done, shape_done, color_in, shape_in, req,
    input  ack, busy, result_out
  );

  modport slave (
    input  vga_vsync_neg, color_done, shape_done, color_in, shape_in, req,
    output ack, busy, result_out
  );
endinterface

// File: rtl/vsync_edge_detect.sv
// Falling-edge detector for the active-low vsync.
//   clk, reset : shared clock and synchronous active-high reset
//   vsync_neg  : raw vsync input
//   fall       : one-cycle pulse when vsync_neg is 0 after a 1 on the previous clock
module vsync_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic vsync_neg,
  output logic fall
);

  logic vsync_prev;

  // History resets to "high" so a vsync already low at reset release is not an edge.
  always_ff @(posedge clk) begin
    if (reset) vsync_prev <= 1'b1;
    else       vsync_prev <= vsync_neg;
  end

  assign fall = vsync_prev & ~vsync_neg;

endmodule

// File: rtl/frame_consensus_ctrl.sv
// Frame consensus controller: on request, samples the processor classification
// at each end of frame and reports once FRAMES_REQ consecutive samples agree,
// or reports a timeout after TIMEOUT_FRAMES samples.
//   clk, reset : clock and synchronous active-high reset
//   bus        : frame_consensus_ctrl_if.slave (processor inputs, req/ack, busy, result_out)
//
// state  | meaning
// IDLE   | waiting for req; ack=0, busy=0
// ARM    | counters cleared, waiting for the first vsync edge (not sampled)
// SAMPLE | one sample per vsync falling edge until consensus or timeout
// DONE   | ack=1, result held until req drops
module frame_consensus_ctrl
  import frame_consensus_ctrl_pkg::*;
#(
  parameter int FRAMES_REQ     = 3,
  parameter int TIMEOUT_FRAMES = 15
) (
  input  logic                   clk,
  input  logic                   reset,
  frame_consensus_ctrl_if.slave  bus
);

  localparam logic [3:0] FRAMES_REQ_C = 4'(FRAMES_REQ);
  localparam logic [7:0] TIMEOUT_C    = 8'(TIMEOUT_FRAMES);

  state_t     state_q, state_d;
  logic [3:0] match_q, match_d;
  logic [7:0] frames_q, frames_d;
  logic [1:0] cand_color_q, cand_color_d;
  logic [2:0] cand_shape_q, cand_shape_d;
  logic [7:0] result_q, result_d;

  logic [1:0] color_q;
  logic [2:0] shape_q;
  logic       color_done_q;
  logic       shape_done_q;

  logic       fall;
  logic [1:0] smp_color;
  logic [2:0] smp_shape;
  logic       hit;

  vsync_edge_detect u_edge (
    .clk       (clk),
    .reset     (reset),
    .vsync_neg (bus.vga_vsync_neg),
    .fall      (fall)
  );

  // Registered copy lets the vsync edge pick up the last pre-sync values.
  always_ff @(posedge clk) begin
    if (reset) begin
      color_q      <= '0;
      shape_q      <= '0;
      color_done_q <= 1'b0;
      shape_done_q <= 1'b0;
    end else begin
      color_q      <= bus.color_in;
      shape_q      <= bus.shape_in;
      color_done_q <= bus.color_done;
      shape_done_q <= bus.shape_done;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      match_q      <= '0;
      frames_q     <= '0;
      cand_color_q <= COLOR_NONE;
      cand_shape_q <= SHAPE_NONE;
      result_q     <= '0;
    end else begin
      state_q      <= state_d;
      match_q      <= match_d;
      frames_q     <= frames_d;
      cand_color_q <= cand_color_d;
      cand_shape_q <= cand_shape_d;
      result_q     <= result_d;
    end
  end

  assign smp_color = form_color(color_done_q, color_q);
  assign smp_shape = form_shape(shape_done_q, shape_q, smp_color);
  assign hit       = (smp_color == cand_color_q) && (smp_shape == cand_shape_q);

  always_comb begin
    state_d      = state_q;
    match_d      = match_q;
    frames_d     = frames_q;
    cand_color_d = cand_color_q;
    cand_shape_d = cand_shape_q;
    result_d     = result_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.req) state_d = ST_ARM;
      end

      ST_ARM: begin
        match_d      = '0;
        frames_d     = '0;
        cand_color_d = COLOR_NONE;
        cand_shape_d = SHAPE_NONE;
        if (!bus.req)  state_d = ST_IDLE;
        else if (fall) state_d = ST_SAMPLE;
      end

      ST_SAMPLE: begin
        if (!bus.req) begin
          state_d = ST_IDLE;
        end else if (fall) begin
          frames_d = (frames_q == 8'hFF) ? frames_q : frames_q + 8'd1;
          if (hit) begin
            match_d = (match_q == 4'hF) ? match_q : match_q + 4'd1;
          end else begin
            cand_color_d = smp_color;
            cand_shape_d = smp_shape;
            match_d      = 4'd1;
          end
          // Consensus is checked first so it wins over a simultaneous timeout.
          if (match_d >= FRAMES_REQ_C) begin
            state_d  = ST_DONE;
            result_d = pack_result(smp_color, smp_shape);
          end else if (frames_d >= TIMEOUT_C) begin
            state_d  = ST_DONE;
            result_d = RESULT_TIMEOUT;
          end
        end
      end

      ST_DONE: begin
        if (!bus.req) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.ack        = (state_q == ST_DONE);
  assign bus.busy       = (state_q == ST_ARM) || (state_q == ST_SAMPLE);
  assign bus.result_out = result_q;

endmodule

// File: doc/frame_consensus_ctrl.md
FRAME_CONSENSUS_CTRL -- requirements
Module: frame_consensus_ctrl

Interface
REQ-001 Parameter FRAMES_REQ, default 3, consecutive identical end-of-frame classifications needed for consensus (range 1..15).
REQ-002 Parameter TIMEOUT_FRAMES, default 15, frames sampled before giving up without consensus (range FRAMES_REQ..255).
REQ-003 CLK  input  1  sole clock; all state changes on its rising edge.
REQ-004 RESET  input  1  synchronous, active-high reset.
REQ-005 VGA_VSYNC_NEG  input  1  camera/VGA vsync, low during vertical sync; low level = frame boundary.
REQ-006 COLOR_DONE  input  1  image processor color decision valid.
REQ-007 SHAPE_DONE  input  1  image processor shape decision valid.
REQ-008 COLOR_IN  input  2  processor color code: 01 red, 10 blue, 00 none, 11 illegal.
REQ-009 SHAPE_IN  input  3  processor shape code: 001 diamond, 010 triangle, 011 square, 100 other, 000 none.
REQ-010 REQ  input  1  classification request from the Arduino, level, 4-phase.
REQ-011 ACK  output  1  result valid acknowledge, 4-phase.
REQ-012 RESULT_OUT  output  8  [1:0] color, [4:2] shape, [5] reserved 0, [6] timeout, [7] treasure found.
REQ-013 BUSY  output  1  high while frames are being sampled.

Function
REQ-014 States: IDLE, ARM, SAMPLE, DONE; encoding 2 bits from package.
REQ-015 IDLE: ACK=0, BUSY=0; REQ=1 -> ARM next cycle.
REQ-016 ARM: BUSY=1; clear match count, frame count, candidate; on first VGA_VSYNC_NEG falling edge (1 then 0 on consecutive CLK samples) -> SAMPLE; this edge is not sampled.
REQ-017 COLOR_IN, SHAPE_IN, COLOR_DONE, SHAPE_DONE registered every cycle; SAMPLE captures the registered copy on each VGA_VSYNC_NEG falling edge (values from the last cycle before vsync, i.e. end of frame).
REQ-018 Sample formation: color = COLOR_IN if COLOR_DONE and COLOR_IN in {01,10}, else 00; shape = SHAPE_IN if SHAPE_DONE and color!=00, else 000.
REQ-019 Each sample: frame count +1 (saturating 8-bit); if sample equals candidate, match count +1 (saturating 4-bit), else candidate = sample and match count = 1.
REQ-020 Consensus when match count reaches FRAMES_REQ: -> DONE; RESULT_OUT = {found=(color!=00), 0, 0, shape, color} on the same edge.
REQ-021 Timeout when frame count reaches TIMEOUT_FRAMES without consensus: -> DONE; RESULT_OUT = 8'h40.
REQ-022 Consensus and timeout on same sample: consensus wins, bit6=0.
REQ-023 DONE: ACK=1, BUSY=0, RESULT_OUT held; REQ=0 -> IDLE with ACK=0 next cycle.
REQ-024 RESULT_OUT changes only on DONE entry or reset; stays stable through IDLE until next DONE.
REQ-025 REQ falling in ARM or SAMPLE: abort to IDLE next cycle, ACK stays 0, RESULT_OUT unchanged.
REQ-026 VGA_VSYNC_NEG held low for many cycles counts as one edge; no edge ever -> remain in ARM/SAMPLE (no cycle timeout).
REQ-027 Latency: ACK rises the cycle after the falling edge that completes consensus (minimum FRAMES_REQ+1 edges after REQ).

Reset
REQ-028 RESET=1 on a CLK edge: state IDLE, ACK=0, BUSY=0, RESULT_OUT=8'h00, all counters, candidate, and edge history (prev vsync = 1) cleared.
REQ-029 RESET overrides every other input, including mid-SAMPLE and DONE.

Structure
REQ-030 Shared package holds state encoding, color/shape code constants, RESULT_OUT bit positions, timeout code 8'h40.
REQ-031 Sub-module vsync_edge_detect: registers VGA_VSYNC_NEG, outputs one-cycle falling-edge pulse; same CLK/RESET.

Verification
REQ-032 Reset mid-SAMPLE after 2 matching frames -> next cycle IDLE, ACK=0, RESULT_OUT=8'h00.
REQ-033 REQ=1, 4 vsync edges, each frame COLOR_IN=01 SHAPE_IN=011 done=1 -> ACK=1 after 4th edge, RESULT_OUT=8'h8D; drop REQ -> ACK=0 next cycle.
REQ-034 Frames blue/triangle, blue/diamond, blue/diamond, blue/diamond -> RESULT_OUT=8'h86, ACK after 5th edge total.
REQ-035 Alternating red/square and blue/square for 15 frames -> RESULT_OUT=8'h40, ACK=1.
REQ-036 COLOR_IN=11 or COLOR_DONE=0 for 3 frames -> RESULT_OUT=8'h00 (consensus "none"), bit7=0.
REQ-037 REQ dropped after 2nd sampled frame -> IDLE, ACK never rises, RESULT_OUT keeps previous value.
